// File: rtl/phv_mcast_dispatcher.sv
// ----------------------------------------------------------------------------
// phv_mcast_dispatcher
//
// Holds the final PHV from the action engine and fans it out to the
// output-queue PHV FIFOs selected by the destination bitmap carried inside
// the PHV. Each destination port takes the held PHV independently, so one
// stalled queue does not block the others. A new PHV is accepted only once
// every requested port has taken the current one. Per-port delivery counters
// and an empty-bitmap drop counter are kept for the control plane.
//
// Ports:
//   axis_clk        clock
//   aresetn         synchronous active-low reset
//   phv_in          PHV from the action engine
//   phv_in_valid    phv_in valid
//   phv_in_ready    dispatcher can accept phv_in this cycle
//   phv_out         held PHV, shared by all ports
//   phv_out_valid   bit i: phv_out offered to port i
//   phv_fifo_ready  bit i: port i FIFO accepts
//   stat_clr        synchronous clear of all counters
//   stat_port_cnt   per-port delivered count, port i at [i*CNT_W +: CNT_W]
//   stat_drop_cnt   number of PHVs dropped for an empty bitmap
//   busy            a PHV is held
// ----------------------------------------------------------------------------
module phv_mcast_dispatcher #(
    parameter int PHV_LEN      = 32*64+256,
    parameter int C_NUM_QUEUES = 4,
    parameter int DST_OFF      = 141,
    parameter int CNT_W        = 32
) (
    input  logic                            axis_clk,
    input  logic                            aresetn,
    input  logic [PHV_LEN-1:0]              phv_in,
    input  logic                            phv_in_valid,
    output logic                            phv_in_ready,
    output logic [PHV_LEN-1:0]              phv_out,
    output logic [C_NUM_QUEUES-1:0]         phv_out_valid,
    input  logic [C_NUM_QUEUES-1:0]         phv_fifo_ready,
    input  logic                            stat_clr,
    output logic [C_NUM_QUEUES*CNT_W-1:0]   stat_port_cnt,
    output logic [CNT_W-1:0]                stat_drop_cnt,
    output logic                            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                    state;
    logic [C_NUM_QUEUES-1:0]   pending;
    logic [PHV_LEN-1:0]        phv_hold;
    logic [C_NUM_QUEUES-1:0]   fire;
    logic [C_NUM_QUEUES-1:0]   remaining;
    logic [C_NUM_QUEUES-1:0]   mask;
    logic                      accept;
    logic                      drop;
    logic [CNT_W-1:0]          port_cnt [C_NUM_QUEUES];
    logic [CNT_W-1:0]          drop_cnt;

    assign phv_out       = phv_hold;
    assign phv_out_valid = (state == HOLD) ? pending : '0;
    assign busy          = (state == HOLD);

    assign fire      = phv_out_valid & phv_fifo_ready;
    assign remaining = pending & ~fire;

    // Ready looks through the downstream ready bits so that a PHV whose last
    // ports take it this cycle can be replaced immediately (1 PHV/cycle).
    assign phv_in_ready = (state == IDLE) || (remaining == '0);

    assign mask   = phv_in[DST_OFF +: C_NUM_QUEUES];
    assign accept = phv_in_valid && phv_in_ready;
    assign drop   = accept && (mask == '0);

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state    <= IDLE;
            pending  <= '0;
            phv_hold <= '0;
        end else if (accept) begin
            // Accept implies remaining==0, so the outgoing PHV is complete and
            // may be overwritten in the same cycle.
            if (mask != '0) begin
                phv_hold <= phv_in;
                pending  <= mask;
                state    <= HOLD;
            end else begin
                pending  <= '0;
                state    <= IDLE;
            end
        end else if (state == HOLD) begin
            pending <= remaining;
            if (remaining == '0) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            for (int i = 0; i < C_NUM_QUEUES; i++) begin
                port_cnt[i] <= '0;
            end
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < C_NUM_QUEUES; i++) begin
                if (stat_clr) begin
                    port_cnt[i] <= '0;
                end else if (fire[i]) begin
                    port_cnt[i] <= port_cnt[i] + CNT_W'(1);
                end
            end
            if (stat_clr) begin
                drop_cnt <= '0;
            end else if (drop) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < C_NUM_QUEUES; g++) begin : g_cnt_pack
        assign stat_port_cnt[g*CNT_W +: CNT_W] = port_cnt[g];
    end

    assign stat_drop_cnt = drop_cnt;

endmodule

// File: doc/phv_mcast_dispatcher.md
Name: phv_mcast_dispatcher

Overview:
Sits after the last match-action stage and fans the final PHV out to the C_NUM_QUEUES output-queue PHV FIFOs. Destination is a one-hot/multi-hot bitmap carried in the PHV. The dispatcher holds one PHV and lets each destination port take it independently, so a stalled queue does not block delivery to the others. It releases upstream only once every requested port has accepted. It also keeps per-port delivery counters and a drop counter for the control plane.

Parameters:
PHV_LEN, 32*64+256, PHV width in bits
C_NUM_QUEUES, 4, number of output ports (supported range 1-8)
DST_OFF, 141, LSB of the destination bitmap in the PHV; bitmap = phv[DST_OFF +: C_NUM_QUEUES]
CNT_W, 32, width of each statistics counter

Ports:
axis_clk  in  1  clock
aresetn  in  1  synchronous active-low reset
phv_in  in  PHV_LEN  PHV from the action engine
phv_in_valid  in  1  phv_in valid
phv_in_ready  out  1  dispatcher can accept phv_in this cycle
phv_out  out  PHV_LEN  held PHV, shared by all ports
phv_out_valid  out  C_NUM_QUEUES  bit i: phv_out offered to port i
phv_fifo_ready  in  C_NUM_QUEUES  bit i: port i FIFO accepts
stat_clr  in  1  synchronous clear of all counters
stat_port_cnt  out  C_NUM_QUEUES*CNT_W  per-port delivered count; port i at [i*CNT_W +: CNT_W]
stat_drop_cnt  out  CNT_W  PHVs with an empty bitmap
busy  out  1  a PHV is held

Behaviour:
- Reset and interface: aresetn is synchronous, active-low; clock is axis_clk.
- Reset values: state=IDLE, pending=0, phv_hold=0, phv_out=0, phv_out_valid=0, busy=0, all counters=0, phv_in_ready=1.
- State: IDLE/HOLD, plus a pending[C_NUM_QUEUES] register and a phv_hold register. phv_out=phv_hold. phv_out_valid = pending when in HOLD, else 0. busy = (state==HOLD).
- fire[i] = phv_out_valid[i] & phv_fifo_ready[i]. remaining = pending & ~fire.
- phv_in_ready = (state==IDLE) | (remaining==0). This is a combinational path from phv_fifo_ready to phv_in_ready and is intentional: it gives back-to-back throughput of 1 PHV/cycle when all requested ports are ready.
- Accept occurs when phv_in_valid & phv_in_ready. Let mask = phv_in[DST_OFF +: C_NUM_QUEUES].
- Accept with mask!=0: phv_hold<=phv_in, pending<=mask, state<=HOLD. The PHV is offered on the next cycle, so valid-to-valid latency is 1 cycle.
- Accept with mask==0: PHV dropped, stat_drop_cnt++. Next state is IDLE, unless a held PHV is still pending, which cannot happen because accept requires remaining==0.
- HOLD, no accept: pending<=remaining; if remaining==0, state<=IDLE.
- HOLD where the final fire and a new accept happen in the same cycle: the new PHV is loaded. The outgoing PHV's fires are still counted.
- Port counters: stat_port_cnt[i] increments by 1 on every fire[i], and several ports may increment in the same cycle. Counters wrap modulo 2^CNT_W.
- stat_clr has priority over increments in the same cycle; the counter reads 0 afterwards.
- Once asserted, phv_out_valid[i] stays high until fire[i]; it is never withdrawn. phv_out stays stable while any pending bit is set.
- phv_in is sampled only on accept. phv_in_valid without ready has no effect.
- Reset mid-HOLD: the held PHV is discarded, no partial delivery is recorded, and the block returns to reset values.
- Bitmap bits outside C_NUM_QUEUES are ignored.

Test Plan:
1. Single unicast: phv_in with bitmap 4'b0100 and all ready=1. Expect phv_out_valid=4'b0100 for exactly 1 cycle, one cycle after accept; stat_port_cnt[2]=1; busy returns to 0.
2. Multicast with staggered readiness: bitmap 4'b1011, ready=4'b0001 for 3 cycles, then 4'b1010. Expect valid 1011 → 1010 (held 3 cycles) → 0. phv_in_ready stays 0 until the cycle ports 1 and 3 fire. Counters for ports 0, 1 and 3 each read 1.
3. Back-to-back streaming: 8 consecutive PHVs with bitmap 4'b1111 and all ready=1. Expect phv_in_ready=1 every cycle, 8 outputs in 8 cycles, and every stat_port_cnt=8.
4. Empty bitmap: PHV with bitmap 0 while IDLE. Expect accept in 1 cycle, no phv_out_valid, stat_drop_cnt=1.
5. stat_clr on the same cycle as a port-0 fire. Expect stat_port_cnt[0]=0 the next cycle. Also preload a counter to 32'hFFFFFFFF via repeated fires in sim and check it wraps to 0.
6. aresetn deasserted while HOLD with pending=4'b0110 and ready=0. Expect phv_out_valid=0, busy=0, counters=0, phv_in_ready=1 on the cycle after reset.
